// File: rtl/apb_initiator.sv
// APB-side transfer engine of the AXI2APB bridge: replays one burst command as
// single APB3 transfers, moving data through the write/read FIFOs.
module apb_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  input  logic                  wfifo_empty,
  input  logic [DATA_WIDTH-1:0] wfifo_rdata,
  output logic                  wfifo_rden,
  input  logic                  rfifo_full,
  output logic                  rfifo_wren,
  output logic [DATA_WIDTH-1:0] rfifo_wdata,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic [1:0]            done_resp,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [2:0] {IDLE, CHECK, SETUP, ACCESS, RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                  state;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [3:0]              cnt;
  logic                    err;

  // WRAP only wraps for 2/4/8/16-beat bursts; other lengths behave as INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [1:0]            burst,
    input logic [3:0]            len,
    input logic [2:0]            size
  );
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    inc  = ADDR_ONE << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_ONE) << size) - ADDR_ONE;
    case (burst)
      2'b00:   return a;
      2'b10: begin
        if (len inside {4'd1, 4'd3, 4'd7, 4'd15})
          return (a & ~mask) | ((a + inc) & mask);
        else
          return a + inc;
      end
      default: return a + inc;
    endcase
  endfunction

  // NOTE: the FIFO strobes must fire in the same cycle as the condition that
  // causes them, so they are decoded from state and inputs rather than registered.
  assign wfifo_rden  = (state == CHECK) && write_q && !wfifo_empty;
  assign rfifo_wren  = (state == ACCESS) && !write_q && pready;
  assign rfifo_wdata = rfifo_wren ? prdata : '0;

  // NOTE: every register here uses <= so all branches see the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      cmd_ready  <= 1'b1;
      done_valid <= 1'b0;
      done_resp  <= 2'b00;
      paddr      <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            write_q   <= cmd_write;
            addr_q    <= cmd_addr;
            len_q     <= cmd_len;
            size_q    <= cmd_size;
            burst_q   <= cmd_burst;
            cnt       <= '0;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (write_q ? !wfifo_empty : !rfifo_full) begin
            if (write_q) pwdata <= wfifo_rdata;
            paddr  <= addr_q;
            pwrite <= write_q;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            err     <= err | pslverr;
            psel    <= 1'b0;
            penable <= 1'b0;
            if (cnt == len_q) begin
              done_valid <= 1'b1;
              done_resp  <= {err | pslverr, 1'b0};
              state      <= RESP;
            end else begin
              addr_q <= next_addr(addr_q, burst_q, len_q, size_q);
              cnt    <= cnt + 4'd1;
              state  <= CHECK;
            end
          end
        end
        RESP: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Scoreboard bench for apb_initiator: directed scenarios followed by randomized
// bursts, checked against an arithmetic model of the burst address rules.
module tb_apb_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] RD_KEY = 32'h5A5A_0F0F;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [3:0]    cmd_len = '0;
  logic [2:0]    cmd_size = '0;
  logic [1:0]    cmd_burst = '0;
  logic          wfifo_empty = 1'b1;
  logic [DW-1:0] wfifo_rdata = '0;
  logic          wfifo_rden;
  logic          rfifo_full = 1'b0;
  logic          rfifo_wren;
  logic [DW-1:0] rfifo_wdata;
  logic          done_valid;
  logic          done_ready = 1'b1;
  logic [1:0]    done_resp;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b1;
  logic          pslverr = 1'b0;

  apb_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wfifo_empty(wfifo_empty), .wfifo_rdata(wfifo_rdata), .wfifo_rden(wfifo_rden),
    .rfifo_full(rfifo_full), .rfifo_wren(rfifo_wren), .rfifo_wdata(rfifo_wdata),
    .done_valid(done_valid), .done_ready(done_ready), .done_resp(done_resp),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_rdata[$];
  logic [1:0]  exp_resp[$];
  logic [31:0] wq[$];

  // Reference address of beat i: wrap bursts stay inside an aligned window of
  // (len+1)*bytes, everything else walks linearly modulo 2^32.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [1:0] burst,
                                            input int len, input int size, input int i);
    longint unsigned bytes, total, base, off, s;
    s     = {32'b0, start};
    bytes = 64'd1 << size;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      total = bytes * longint'(len + 1);
      base  = (s / total) * total;
      off   = s - base;
      return 32'(base + (off + longint'(i) * bytes) % total);
    end
    return 32'(s + longint'(i) * bytes);
  endfunction

  // Environment knobs shared by the stimulus and the FIFO/completer driver.
  int          wstall_pct = 0, fstall_pct = 0, wait_pct = 0, dstall_pct = 0;
  int          wait_left = 0;
  int          stall_idx = -1, stall_left = 0;
  logic [15:0] cur_err_mask = '0;
  int          slave_beat = 0;
  logic        pop_now, drv_beat_done, drv_accept, stalled;

  // FIFO and APB completer models: sample at negedge, drive just after posedge.
  always begin
    @(negedge clk);
    pop_now       = wfifo_rden && !rst;
    drv_beat_done = psel && penable && pready && !rst;
    drv_accept    = cmd_valid && cmd_ready && !rst;
    @(posedge clk);
    #1;
    if (pop_now && wq.size() > 0) void'(wq.pop_front());
    if (rst || drv_accept) slave_beat = 0;
    else if (drv_beat_done) slave_beat++;
    stalled = (slave_beat == stall_idx) && (stall_left > 0) && !psel && !done_valid;
    if (stalled) stall_left--;
    wfifo_empty = stalled || (wq.size() == 0) || ($urandom_range(99) < wstall_pct);
    wfifo_rdata = (wq.size() > 0) ? wq[0] : '0;
    rfifo_full  = stalled || ($urandom_range(99) < fstall_pct);
    if (psel && penable && wait_left > 0) begin
      pready = 1'b0;
      wait_left--;
    end else begin
      pready = ($urandom_range(99) >= wait_pct);
    end
    prdata     = paddr ^ RD_KEY;
    pslverr    = cur_err_mask[slave_beat & 15];
    done_ready = ($urandom_range(99) >= dstall_pct);
  end

  // Monitor / scoreboard.
  int          gap = 0, setup_idx = 0, acc = 0, last_acc = 0, done_count = 0;
  int          gaps[16];
  logic        prev_wait = 1'b0;
  logic [31:0] prev_paddr, prev_pwdata;
  beat_t       mb;

  always @(negedge clk) begin
    if (rst) begin
      prev_wait = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        gap = 0;
        setup_idx = 0;
      end else if (psel && !penable) begin
        if (setup_idx < 16) gaps[setup_idx] = gap;
        setup_idx++;
        gap = 0;
        acc = 0;
      end else if (!psel) begin
        gap++;
      end
      if (psel && penable) acc++;
      if (psel || done_valid) check("cmd_ready_busy", 64'(cmd_ready), 0);
      if (penable) check("penable_needs_psel", 64'(psel), 1);
      if (psel && penable && prev_wait) begin
        check("hold_paddr", 64'(paddr), 64'(prev_paddr));
        check("hold_pwdata", 64'(pwdata), 64'(prev_pwdata));
      end
      if (wfifo_rden) check("rden_while_empty", 64'(wfifo_empty), 0);
      if (psel && penable && pready) begin
        last_acc = acc;
        check("beat_expected", 64'(exp_beats.size() > 0), 1);
        if (exp_beats.size() > 0) begin
          mb = exp_beats.pop_front();
          check("apb_paddr", 64'(paddr), 64'(mb.addr));
          check("apb_pwrite", 64'(pwrite), 64'(mb.write));
          if (mb.write) check("apb_pwdata", 64'(pwdata), 64'(mb.wdata));
        end
      end
      if (rfifo_wren) begin
        check("push_expected", 64'(exp_rdata.size() > 0), 1);
        if (exp_rdata.size() > 0) check("rfifo_wdata", 64'(rfifo_wdata), 64'(exp_rdata.pop_front()));
      end
      if (done_valid && done_ready) begin
        check("done_expected", 64'(exp_resp.size() > 0), 1);
        if (exp_resp.size() > 0) check("done_resp", 64'(done_resp), 64'(exp_resp.pop_front()));
        done_count++;
      end
      prev_wait   = psel && penable && !pready;
      prev_paddr  = paddr;
      prev_pwdata = pwdata;
    end
  end

  // Builds expectations, presents the command and waits for its acceptance.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst,
                       input logic [15:0] emask, input logic [31:0] seed);
    beat_t       b;
    logic [31:0] d;
    logic        any_err;
    int          n;
    any_err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      b.addr  = beat_addr(a, burst, int'(len), int'(size), i);
      b.write = wr;
      d       = (seed != 0) ? seed + 32'(i) : $urandom;
      b.wdata = wr ? d : '0;
      if (wr) wq.push_back(d);
      else exp_rdata.push_back(b.addr ^ RD_KEY);
      exp_beats.push_back(b);
      any_err |= emask[i];
    end
    exp_resp.push_back(any_err ? 2'b10 : 2'b00);
    cur_err_mask = emask;
    cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_size = size; cmd_burst = burst;
    cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 3000);
    check("cmd_accept", 64'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_count < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_in_time", 64'(done_count >= target), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input logic wr, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [15:0] emask, input logic [31:0] seed);
    int t;
    t = done_count + 1;
    issue(wr, a, len, size, burst, emask, seed);
    wait_done(t);
  endtask

  initial begin
    int t, n;
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 1);
    check("rst_psel", 64'(psel), 0);
    check("rst_penable", 64'(penable), 0);
    check("rst_done_valid", 64'(done_valid), 0);
    check("rst_paddr", 64'(paddr), 0);
    check("rst_strobes", 64'({wfifo_rden, rfifo_wren}), 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single write with exact cycle timing.
    t = done_count + 1;
    issue(1'b1, 32'h100, 4'd0, 3'd2, 2'b01, 16'h0, 32'hDEADBEEF);
    @(negedge clk);
    check("c1_rden", 64'(wfifo_rden), 1);
    check("c1_psel", 64'(psel), 0);
    @(negedge clk);
    check("c2_setup", 64'({psel, penable}), 64'(2'b10));
    check("c2_paddr", 64'(paddr), 64'h100);
    @(negedge clk);
    check("c3_access", 64'({psel, penable}), 64'(2'b11));
    check("c3_pwdata", 64'(pwdata), 64'hDEADBEEF);
    @(negedge clk);
    check("c4_done_valid", 64'(done_valid), 1);
    @(negedge clk);
    check("c5_idle", 64'({cmd_ready, done_valid}), 64'(2'b10));
    wait_done(t);

    // INCR read, WRAP write, FIXED write, INCR across the top of the address space.
    run_burst(1'b0, 32'h200, 4'd3, 3'd2, 2'b01, 16'h0, 32'h0);
    check("incr_gap", 64'(gaps[3]), 1);
    run_burst(1'b1, 32'h3C, 4'd3, 3'd2, 2'b10, 16'h0, 32'h0);
    run_burst(1'b1, 32'h3C, 4'd2, 3'd2, 2'b00, 16'h0, 32'h0);
    run_burst(1'b0, 32'hFFFF_FFF8, 4'd3, 3'd2, 2'b01, 16'h0, 32'h0);

    // Write FIFO empty for 5 cycles before beat 2.
    stall_idx = 2; stall_left = 5;
    run_burst(1'b1, 32'h400, 4'd3, 3'd2, 2'b01, 16'h0, 32'h0);
    check("wstall_gap", 64'(gaps[2]), 6);
    check("wnostall_gap", 64'(gaps[1]), 1);
    // Read FIFO full for 5 cycles before beat 1.
    stall_idx = 1; stall_left = 5;
    run_burst(1'b0, 32'h480, 4'd1, 3'd2, 2'b01, 16'h0, 32'h0);
    check("rstall_gap", 64'(gaps[1]), 6);
    stall_idx = -1;

    // Three wait states.
    wait_left = 3;
    run_burst(1'b1, 32'h600, 4'd0, 3'd2, 2'b01, 16'h0, 32'h12345678);
    check("wait_access_len", 64'(last_acc), 4);

    // SLVERR on beat 1, then a clean burst.
    run_burst(1'b0, 32'h700, 4'd3, 3'd2, 2'b01, 16'h0002, 32'h0);
    run_burst(1'b0, 32'h700, 4'd3, 3'd2, 2'b01, 16'h0000, 32'h0);

    // Reset in the middle of a stalled ACCESS.
    wait_left = 1000;
    issue(1'b0, 32'h500, 4'd3, 3'd2, 2'b01, 16'h0, 32'h0);
    n = 0;
    while (!(psel && penable) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_access", 64'(psel && penable), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_psel", 64'(psel), 0);
    check("mid_rst_penable", 64'(penable), 0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 1);
    check("mid_rst_done_valid", 64'(done_valid), 0);
    exp_beats.delete(); exp_rdata.delete(); exp_resp.delete(); wq.delete();
    wait_left = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    run_burst(1'b1, 32'h800, 4'd1, 3'd2, 2'b01, 16'h0, 32'h0);

    // Randomized bursts under random back-pressure.
    wstall_pct = 20; fstall_pct = 20; wait_pct = 30; dstall_pct = 30;
    for (int k = 0; k < 60; k++) begin
      logic [2:0] sz;
      sz = ($urandom_range(3) == 0) ? 3'($urandom) : 3'($urandom_range(2));
      run_burst(1'($urandom), $urandom, 4'($urandom), sz, 2'($urandom),
                ($urandom_range(3) == 0) ? 16'($urandom) : 16'h0, 32'h0);
    end

    check("beats_drained", 64'(exp_beats.size()), 0);
    check("pushes_drained", 64'(exp_rdata.size()), 0);
    check("resps_drained", 64'(exp_resp.size()), 0);
    check("wfifo_drained", 64'(wq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
# apb_initiator

APB-side transfer engine of the AXI2APB bridge: accepts one burst command at a time from the bridge engine and replays it as a sequence of single APB3 transfers. Write beats consume data from the write-data FIFO filled by the AXI reader; read beats push data into the read-data FIFO drained by the AXI writer. When the burst finishes, a single completion response is returned to the engine.

## Interface
Parameters:
- ADDR_WIDTH, 32, APB/AXI address width
- DATA_WIDTH, 32, APB data width. Must be 8, 16, 32 or 64.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  4  number of beats minus 1
- cmd_size  in  3  log2(bytes per beat)
- cmd_burst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- wfifo_empty  in  1  write-data FIFO empty
- wfifo_rdata  in  DATA_WIDTH  FIFO head; show-ahead, valid while not empty
- wfifo_rden  out  1  pop the write-data FIFO
- rfifo_full  in  1  read-data FIFO full
- rfifo_wren  out  1  push to the read-data FIFO
- rfifo_wdata  out  DATA_WIDTH  data pushed to the read-data FIFO
- done_valid  out  1  burst completion valid
- done_ready  in  1  engine accepts the completion
- done_resp  out  2  00 OKAY, 10 SLVERR
- paddr  out  ADDR_WIDTH  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB completer ready
- pslverr  in  1  APB error

## Operation
- FSM states: IDLE, CHECK, SETUP, ACCESS, RESP.
- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid: latch write, addr, len, size and burst. Clear the beat counter and the error flag. Go to CHECK.
- **CHECK**
  - Write burst: stay here while wfifo_empty. Otherwise assert wfifo_rden for one cycle, capture wfifo_rdata into pwdata, and go to SETUP.
  - Read burst: stay here while rfifo_full. Otherwise go to SETUP.
- **SETUP**
  - psel = 1, penable = 0.
  - paddr = current beat address; pwrite = latched write bit.
  - Always go to ACCESS.
- **ACCESS**
  - psel = 1, penable = 1.
  - While pready = 0: stay here; hold paddr, pwrite and pwdata stable.
  - On pready = 1:
    - Error flag |= pslverr.
    - Read burst: rfifo_wren = 1 and rfifo_wdata = prdata in that cycle. Data is pushed even when pslverr = 1.
    - If this was the last beat (counter == len), go to RESP.
    - Otherwise advance the address, increment the counter, and go to CHECK.
- **RESP**
  - done_valid = 1; done_resp = error flag ? 10 : 00.
  - Hold until done_ready, then go to IDLE.
- **Address update**, inc = 1 << size, ADDR_WIDTH arithmetic wrapping modulo 2^ADDR_WIDTH:
  - FIXED: address unchanged.
  - INCR and reserved 11: address + inc.
  - WRAP with len in {1, 3, 7, 15}: mask = ((len+1) << size) - 1; next = (address & ~mask) | ((address + inc) & mask).
  - WRAP with any other len: treated as INCR.
- cmd_size values above log2(DATA_WIDTH/8) are used as given. No clamping is applied.
- An SLVERR never aborts a burst. All len+1 beats are always issued.
- **Outputs outside their states**
  - psel and penable are 0 outside SETUP and ACCESS.
  - wfifo_rden, rfifo_wren and done_valid are single-purpose strobes and are 0 in all other states.
- **Reset**
  - FSM returns to IDLE immediately, including mid-transfer; the in-flight APB transfer is abandoned.
  - paddr, pwdata, rfifo_wdata, done_resp, the counter and the error flag reset to 0.
  - psel, penable, pwrite, wfifo_rden, rfifo_wren and done_valid reset to 0.
  - cmd_ready = 1 during and after reset.

## Timing
- Command accepted on the edge that cycle 0 ends. Cycle 1 is CHECK, cycle 2 is SETUP, cycle 3 is ACCESS.
- Each beat takes at least 3 cycles: CHECK, SETUP, ACCESS with pready = 1. Every extra cycle of FIFO stall or pready = 0 adds one cycle.
- done_valid rises in the cycle after the last ACCESS that has pready = 1.
- For a single-beat burst with zero waits: done_valid is high in cycle 4; IDLE is reached in cycle 5 if done_ready is high in cycle 4.
- FIFO strobes:
  - wfifo_rden occurs exactly once per write beat, in CHECK.
  - rfifo_wren occurs exactly once per read beat, in ACCESS with pready = 1.
- Between consecutive beats psel drops for exactly the CHECK cycle(s).
- cmd_ready is 0 from cycle 1 until the return to IDLE. No new command is accepted while done_valid is pending.

## Test plan
- Single write: addr 0x100, len 0, INCR, FIFO holds 0xDEADBEEF, pready = 1 → one SETUP/ACCESS with paddr 0x100, pwdata 0xDEADBEEF; one wfifo_rden; done_resp 00 in cycle 4.
- INCR read: addr 0x200, len 3, size 2, prdata = paddr → paddr sequence 0x200, 0x204, 0x208, 0x20C; four rfifo_wren carrying those values; done_resp 00.
- WRAP write: addr 0x3C, len 3, size 2 → paddr sequence 0x3C, 0x30, 0x34, 0x38. FIXED burst with len 2 → paddr 0x3C three times.
- Stalls:
  - Write: wfifo_empty held high for 5 cycles before beat 2 → FSM stays in CHECK with psel = 0, then resumes with correct data.
  - Read: rfifo_full held high → no SETUP until rfifo_full clears.
  - pready = 0 for 3 cycles → paddr and pwdata held stable; beat completes on pready.
- Error: 4-beat read with pslverr on beat 1 → all 4 beats issued, 4 pushes, done_resp 10. The next burst with no errors returns 00.
- Reset mid-ACCESS → psel and penable drop immediately, cmd_ready = 1, done_valid = 0; a new command then executes normally.
